// File: rtl/alu_result_stage.sv
// alu_result_stage: registered stage behind the 32-bit MIPS ALU.
// Qualifies each ALU result (SLT select, branch resolution, overflow trap),
// queues it in a small skid FIFO with valid/ready on both sides, and keeps
// sticky carry/overflow flags plus a count of accepted operations.
// DEPTH must be 2 or 4 so the pointers wrap naturally at their full width.

module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      alu_result,
    input  logic             alu_cout,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_slt,
    input  logic [3:0]       alu_ctrl,
    input  logic             slt_sel,
    input  logic [4:0]       rd_addr,
    input  logic             reg_write,
    input  logic             is_branch,
    input  logic             branch_ne,
    input  logic [31:0]      branch_target,
    input  logic             trap_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             branch_taken,
    output logic [31:0]      branch_pc,
    output logic             ovf_exc,
    input  logic             flag_clr,
    output logic             sticky_c,
    output logic             sticky_v,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   mem_result [DEPTH];
    logic [4:0]    mem_rd     [DEPTH];
    logic          mem_we     [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          in_ready_q;

    logic          accept;
    logic          pop;
    logic          trap;
    logic          take;
    logic          is_addsub;
    logic [31:0]   entry_result;
    logic          entry_we;

    // in_ready comes straight from a flop so the ALU never sees a
    // combinational path from out_ready.
    assign in_ready  = in_ready_q;
    assign out_valid = (count != '0);

    assign accept    = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign trap      = trap_en & alu_ovf;
    assign take      = is_branch & (alu_zero ^ branch_ne);
    assign is_addsub = (alu_ctrl[3:1] == 3'b000);

    // Trapped ops and branches still retire in order but must not write back.
    assign entry_result = slt_sel ? {31'b0, alu_slt} : alu_result;
    assign entry_we     = reg_write & ~trap & ~is_branch;

    // Head outputs read as zero whenever the FIFO is empty.
    assign out_result    = out_valid ? mem_result[rd_ptr] : 32'b0;
    assign out_rd        = out_valid ? mem_rd[rd_ptr]     : 5'b0;
    assign out_reg_write = out_valid & mem_we[rd_ptr];

    // Next occupancy: flush empties, simultaneous push and pop cancel out.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (accept && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !accept) begin
            count_next = count - 1'b1;
        end
    end

    // FIFO bookkeeping: occupancy, pointers and the registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            count      <= count_next;
            in_ready_q <= (count_next < FULL);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (accept) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_result[wr_ptr] <= entry_result;
            mem_rd[wr_ptr]     <= rd_addr;
            mem_we[wr_ptr]     <= entry_we;
        end
    end

    // One-cycle branch and overflow pulses; branch_pc holds the last target taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_taken <= 1'b0;
            branch_pc    <= 32'b0;
            ovf_exc      <= 1'b0;
        end else begin
            branch_taken <= accept & take;
            ovf_exc      <= accept & trap;
            if (accept && take) begin
                branch_pc <= branch_target;
            end
        end
    end

    // Sticky flags: a clear in the same cycle as an accept keeps only the new flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
        end else if (accept) begin
            sticky_v <= (sticky_v & ~flag_clr) | alu_ovf;
            sticky_c <= (sticky_c & ~flag_clr) | (alu_cout & is_addsub);
        end else if (flag_clr) begin
            sticky_v <= 1'b0;
            sticky_c <= 1'b0;
        end
    end

    // Accepted-operation counter, wraps silently and ignores flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed bench for alu_result_stage (DEPTH=2, CNT_W=16).
// A small reference model tracks occupancy, pulses, sticky flags and the
// counter; expected FIFO entries go into a scoreboard queue at accept time and
// are compared whenever the DUT presents a head entry that is being popped.

module tb_alu_result_stage;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_zero;
    logic        alu_ovf;
    logic        alu_slt;
    logic [3:0]  alu_ctrl;
    logic        slt_sel;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        is_branch;
    logic        branch_ne;
    logic [31:0] branch_target;
    logic        trap_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic        ovf_exc;
    logic        flag_clr;
    logic        sticky_c;
    logic        sticky_v;
    logic [15:0] op_count;

    int          checks;
    int          failures;
    entry_t      sb[$];

    int          m_count;
    logic [15:0] m_cnt;
    logic        m_c;
    logic        m_v;
    logic [31:0] m_bpc;

    alu_result_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_zero(alu_zero),
        .alu_ovf(alu_ovf), .alu_slt(alu_slt), .alu_ctrl(alu_ctrl),
        .slt_sel(slt_sel), .rd_addr(rd_addr), .reg_write(reg_write),
        .is_branch(is_branch), .branch_ne(branch_ne), .branch_target(branch_target),
        .trap_en(trap_en), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .branch_taken(branch_taken), .branch_pc(branch_pc), .ovf_exc(ovf_exc),
        .flag_clr(flag_clr), .sticky_c(sticky_c), .sticky_v(sticky_v),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        in_valid      = 1'b0;
        alu_result    = 32'b0;
        alu_cout      = 1'b0;
        alu_zero      = 1'b0;
        alu_ovf       = 1'b0;
        alu_slt       = 1'b0;
        alu_ctrl      = 4'b0;
        slt_sel       = 1'b0;
        rd_addr       = 5'b0;
        reg_write     = 1'b0;
        is_branch     = 1'b0;
        branch_ne     = 1'b0;
        branch_target = 32'b0;
        trap_en       = 1'b0;
        flush         = 1'b0;
        out_ready     = 1'b0;
        flag_clr      = 1'b0;
    endtask

    // One clock cycle with the currently driven inputs, model update and checks.
    task automatic applyStimulus();
        logic   acc;
        logic   pop;
        logic   exp_bt;
        logic   exp_ovf;
        entry_t e;
        checkOutput("in_ready", 32'(in_ready), 32'(m_count < 2));
        checkOutput("out_valid", 32'(out_valid), 32'(m_count != 0));
        acc = in_valid && (m_count < 2) && !flush;
        pop = (m_count != 0) && out_ready && !flush;
        if (acc) begin
            e.result = slt_sel ? {31'b0, alu_slt} : alu_result;
            e.rd     = rd_addr;
            e.we     = reg_write && !(trap_en && alu_ovf) && !is_branch;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (flush) begin
            m_count = 0;
            sb.delete();
        end else begin
            m_count = m_count + int'(acc) - int'(pop);
        end
        exp_bt  = acc && is_branch && (alu_zero ^ branch_ne);
        exp_ovf = acc && trap_en && alu_ovf;
        if (exp_bt) m_bpc = branch_target;
        if (flag_clr) begin
            m_v = 1'b0;
            m_c = 1'b0;
        end
        if (acc) begin
            m_v = m_v | alu_ovf;
            if (alu_ctrl == 4'b0000 || alu_ctrl == 4'b0001) m_c = m_c | alu_cout;
            m_cnt = m_cnt + 16'd1;
        end
        checkOutput("branch_taken", 32'(branch_taken), 32'(exp_bt));
        checkOutput("branch_pc", branch_pc, m_bpc);
        checkOutput("ovf_exc", 32'(ovf_exc), 32'(exp_ovf));
        checkOutput("sticky_v", 32'(sticky_v), 32'(m_v));
        checkOutput("sticky_c", 32'(sticky_c), 32'(m_c));
        checkOutput("op_count", 32'(op_count), 32'(m_cnt));
    endtask

    // Hold reset for two edges, check the reset state, then release it.
    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        sb.delete();
        m_count = 0;
        m_cnt   = 16'd0;
        m_c     = 1'b0;
        m_v     = 1'b0;
        m_bpc   = 32'b0;
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_rd", 32'(out_rd), 0);
        checkOutput("rst_out_reg_write", 32'(out_reg_write), 0);
        checkOutput("rst_branch_taken", 32'(branch_taken), 0);
        checkOutput("rst_branch_pc", branch_pc, 0);
        checkOutput("rst_ovf_exc", 32'(ovf_exc), 0);
        checkOutput("rst_sticky", 32'({sticky_c, sticky_v}), 0);
        checkOutput("rst_op_count", 32'(op_count), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("in_ready_after_rst", 32'(in_ready), 1);
    endtask

    // Scoreboard: a head that is popped this cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            checkOutput("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                entry_t e;
                e = sb.pop_front();
                checkOutput("out_result", out_result, e.result);
                checkOutput("out_rd", 32'(out_rd), 32'(e.rd));
                checkOutput("out_reg_write", 32'(out_reg_write), 32'(e.we));
            end
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clearInputs();
        doReset();

        // Basic accept, one-cycle latency into an empty FIFO
        clearInputs(); in_valid = 1'b1; alu_result = 32'h0000_0005; rd_addr = 5'd3;
        reg_write = 1'b1; out_ready = 1'b1;
        applyStimulus();
        clearInputs(); out_ready = 1'b1;
        checkOutput("basic_out_valid", 32'(out_valid), 1);
        checkOutput("basic_out_result", out_result, 32'h0000_0005);
        checkOutput("basic_out_rd", 32'(out_rd), 3);
        checkOutput("basic_out_reg_write", 32'(out_reg_write), 1);
        checkOutput("basic_op_count", 32'(op_count), 1);
        applyStimulus();

        // Backpressure: third push refused while full, then in-order drain
        for (int i = 1; i <= 3; i++) begin
            clearInputs(); in_valid = 1'b1; alu_result = 32'(i); rd_addr = 5'(i);
            reg_write = 1'b1; alu_cout = 1'b1; alu_ctrl = 4'b0010;
            applyStimulus();
        end
        checkOutput("bp_in_ready_full", 32'(in_ready), 0);
        clearInputs(); out_ready = 1'b1;
        checkOutput("bp_head_first", out_result, 32'd1);
        applyStimulus();
        checkOutput("bp_in_ready_back", 32'(in_ready), 1);
        checkOutput("bp_head_second", out_result, 32'd2);
        applyStimulus();
        checkOutput("bp_empty", 32'(out_valid), 0);

        // Overflow trap: pulse, write-back suppressed, sticky_v set
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; alu_result = 32'h8000_0000;
        alu_ovf = 1'b1; trap_en = 1'b1; reg_write = 1'b1; rd_addr = 5'd7;
        applyStimulus();
        checkOutput("ovf_pulse", 32'(ovf_exc), 1);
        checkOutput("ovf_sticky_v", 32'(sticky_v), 1);
        checkOutput("ovf_out_reg_write", 32'(out_reg_write), 0);
        clearInputs(); out_ready = 1'b1;
        applyStimulus();
        checkOutput("ovf_pulse_width", 32'(ovf_exc), 0);

        // Carry from ADD sets sticky_c; clear+accept keeps only the new flags
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; alu_ctrl = 4'b0000;
        alu_cout = 1'b1; alu_result = 32'h0000_0001; reg_write = 1'b1; rd_addr = 5'd8;
        applyStimulus();
        checkOutput("sticky_c_set", 32'(sticky_c), 1);
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; flag_clr = 1'b1;
        alu_ctrl = 4'b0001; alu_cout = 1'b1; alu_result = 32'h0000_0002; rd_addr = 5'd8;
        applyStimulus();
        checkOutput("clr_sticky_v", 32'(sticky_v), 0);
        checkOutput("clr_then_set_c", 32'(sticky_c), 1);
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; alu_ovf = 1'b1;
        reg_write = 1'b1; rd_addr = 5'd9; alu_result = 32'h7FFF_FFFF;
        applyStimulus();
        clearInputs(); out_ready = 1'b1; flag_clr = 1'b1;
        applyStimulus();
        checkOutput("clr_alone", 32'({sticky_c, sticky_v}), 0);

        // Branch resolution
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; is_branch = 1'b1; branch_ne = 1'b1;
        alu_zero = 1'b0; branch_target = 32'h0040_0020; reg_write = 1'b1; rd_addr = 5'd4;
        alu_result = 32'h0000_1234;
        applyStimulus();
        checkOutput("bne_taken", 32'(branch_taken), 1);
        checkOutput("bne_pc", branch_pc, 32'h0040_0020);
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; is_branch = 1'b1; branch_ne = 1'b1;
        alu_zero = 1'b1; branch_target = 32'h0040_0080; reg_write = 1'b1; rd_addr = 5'd4;
        applyStimulus();
        checkOutput("bne_not_taken", 32'(branch_taken), 0);
        checkOutput("bne_pc_hold", branch_pc, 32'h0040_0020);
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; is_branch = 1'b1; branch_ne = 1'b0;
        alu_zero = 1'b1; branch_target = 32'h0040_0100;
        applyStimulus();
        checkOutput("beq_taken", 32'(branch_taken), 1);
        clearInputs(); out_ready = 1'b1;
        applyStimulus();

        // SLT result selection
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; slt_sel = 1'b1;
        alu_result = 32'hFFFF_FFFF; alu_slt = 1'b1; reg_write = 1'b1; rd_addr = 5'd12;
        applyStimulus();
        clearInputs(); out_ready = 1'b1;
        checkOutput("slt_result", out_result, 32'h0000_0001);
        applyStimulus();

        // Flush with a full FIFO, in_valid and out_ready all at once
        clearInputs(); in_valid = 1'b1; alu_result = 32'h0000_000A; rd_addr = 5'd10; reg_write = 1'b1;
        applyStimulus();
        clearInputs(); in_valid = 1'b1; alu_result = 32'h0000_000B; rd_addr = 5'd11; reg_write = 1'b1;
        applyStimulus();
        clearInputs(); flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; alu_result = 32'h0000_000C;
        applyStimulus();
        checkOutput("flush_out_valid", 32'(out_valid), 0);
        checkOutput("flush_in_ready", 32'(in_ready), 1);

        // Flush drops a would-be-accepted branch/trap op with no side effects
        clearInputs(); in_valid = 1'b1; alu_result = 32'h0000_000D; rd_addr = 5'd13; reg_write = 1'b1;
        applyStimulus();
        clearInputs(); flush = 1'b1; in_valid = 1'b1; is_branch = 1'b1; alu_zero = 1'b1;
        branch_target = 32'h0BAD_0000; trap_en = 1'b1; alu_ovf = 1'b1; alu_cout = 1'b1;
        applyStimulus();
        checkOutput("flush_drop_branch", 32'(branch_taken), 0);
        checkOutput("flush_drop_ovf", 32'(ovf_exc), 0);
        checkOutput("flush_drop_sticky_v", 32'(sticky_v), 0);

        // Reset during activity: buffered entry and pending pulse are lost
        clearInputs(); in_valid = 1'b1; is_branch = 1'b1; alu_zero = 1'b1;
        branch_target = 32'h0040_0200; rd_addr = 5'd2;
        applyStimulus();
        doReset();

        // Counter wrap: stream accepts until all-ones, then one more
        for (int n = 0; n < 70000 && m_cnt != 16'hFFFF; n++) begin
            clearInputs(); in_valid = 1'b1; out_ready = 1'b1; reg_write = 1'b1;
            alu_result = $urandom(); rd_addr = 5'($urandom_range(31, 0));
            applyStimulus();
        end
        checkOutput("cnt_all_ones", 32'(op_count), 32'h0000_FFFF);
        clearInputs(); in_valid = 1'b1; out_ready = 1'b1; alu_result = 32'h0000_0077; rd_addr = 5'd1;
        applyStimulus();
        checkOutput("cnt_wrap", 32'(op_count), 0);

        clearInputs(); out_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 32-bit ALU in the MIPS datapath.
- Captures the ALU Result and flags, then applies SLT result selection, branch resolution and overflow-trap qualification.
- Buffers up to 2 entries in a skid FIFO with valid/ready handshakes on both sides, so the memory stage can stall without creating a combinational ready path back into the ALU.
- Also keeps sticky status flags and a retired-operation counter.

Parameters:
- DEPTH, 2: FIFO entries. Legal values are 2 or 4.
- CNT_W, 16: width of the accepted-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU output is valid this cycle.
- in_ready  out  1  stage can accept an entry; registered.
- alu_result  in  32  ALU Result.
- alu_cout  in  1  ALU Cout.
- alu_zero  in  1  ALU ZeroFlag.
- alu_ovf  in  1  ALU OverflowFlag.
- alu_slt  in  1  ALU SLTFlag.
- alu_ctrl  in  4  ALU ALUControl echo.
- slt_sel  in  1  the instruction is SLT/SLTU.
- rd_addr  in  5  destination register.
- reg_write  in  1  write-back enable.
- is_branch  in  1  the instruction is BEQ/BNE.
- branch_ne  in  1  1 means BNE, 0 means BEQ.
- branch_target  in  32  computed branch target.
- trap_en  in  1  signed op (ADD/SUB); trap on overflow.
- flush  in  1  discard all buffered and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head.
- out_result  out  32  head result.
- out_rd  out  5  head destination register.
- out_reg_write  out  1  head write-back enable, already qualified.
- branch_taken  out  1  one-cycle pulse.
- branch_pc  out  32  target, valid while branch_taken = 1.
- ovf_exc  out  1  one-cycle overflow-exception pulse.
- flag_clr  in  1  clears the sticky flags.
- sticky_c  out  1  OR of Cout over accepted ADD/SUB.
- sticky_v  out  1  OR of OverflowFlag over accepted ops.
- op_count  out  CNT_W  number of accepted entries.

Behaviour:
- Reset:
  - Every output is 0, except in_ready, which is 1 in the cycle after rst deasserts.
  - FIFO count = 0; rd/wr pointers = 0.
  - rst has priority over all other inputs.
- Accept: in_valid & in_ready & ~flush.
- Handshake rules:
  - in_ready = (count < DEPTH) computed from registered count.
  - When count = DEPTH and a pop occurs in the same cycle, in_ready stays 0 for that cycle; no bypass.
  - out_valid = (count != 0).
  - Pop: out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Head data is stable while out_valid & ~out_ready.
- Entry computation at accept:
  - Result: if slt_sel, stored result = {31'b0, alu_slt}; otherwise alu_result.
  - Overflow trap: if trap_en & alu_ovf, stored reg_write = 0 and ovf_exc pulses 1 the next cycle. The entry is still pushed so retirement order is preserved.
  - Branch: if is_branch & (alu_zero ^ branch_ne), then next cycle branch_taken = 1 and branch_pc = branch_target. Otherwise branch_taken = 0. branch_pc holds its last value.
  - A branch entry is pushed with reg_write forced to 0.
- Latency: data appears at out_* one cycle after accept when the FIFO was empty.
- Sticky flags:
  - On accept: sticky_v |= alu_ovf.
  - sticky_c |= alu_cout only when alu_ctrl is 4'b0000 or 4'b0001.
  - flag_clr with a simultaneous accept: the register takes the new accept's flags only (clear, then set).
- op_count:
  - Increments by 1 on accept.
  - Wraps from all-ones to 0 with no flag.
  - Not affected by flush.
- Flush:
  - Next cycle count = 0, out_valid = 0, pointers = 0, in_ready = 1.
  - An in_valid in the flush cycle is dropped: no push, no pulse, no sticky or counter update.
  - A pop in the same cycle is ignored.
- Pointers: wrap modulo DEPTH.
- Reset during activity: all buffered entries are lost with no pulses emitted. The upstream stage must replay.

Test Plan:
- Reset, then in_valid with alu_result=32'h0000_0005, rd_addr=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=5, out_rd=3, out_reg_write=1; op_count=1.
- out_ready=0, push 3 entries (values 1, 2, 3) -> in_ready=0 after the 2nd push and the 3rd is not accepted. Then out_ready=1 -> pops 1 then 2 in order; in_ready returns to 1 the cycle after the first pop.
- Push alu_ovf=1 with trap_en=1, reg_write=1 -> ovf_exc pulses for 1 cycle, out_reg_write=0, sticky_v=1. Then flag_clr with a simultaneous push where alu_ovf=0 -> sticky_v=0.
- BNE: is_branch=1, branch_ne=1, alu_zero=0, branch_target=32'h0040_0020 -> next cycle branch_taken=1, branch_pc=32'h0040_0020. Same op with alu_zero=1 -> branch_taken=0.
- slt_sel=1, alu_result=32'hFFFF_FFFF, alu_slt=1 -> out_result=32'h0000_0001.
- Fill 2 entries, then assert flush together with in_valid and out_ready -> next cycle out_valid=0 and in_ready=1; op_count unchanged by the dropped entry. Set op_count to 16'hFFFF, accept one entry -> op_count=0.
